// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch stage.
// Holds the PC and picks the next one from sequential, branch/jump redirect,
// return-address stack (RAS) pop, or exception vector. Captures EPC on
// exceptions and on misaligned redirects, and keeps a circular RAS that
// overwrites its oldest entry when pushed while full.
module pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'('h180),
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            exc_req,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            call,
  input  logic            ret,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] epc,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            misalign_err,
  output logic            ras_underflow
);

  localparam int PW    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = PW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  // Where the next PC comes from; decoded from the priority chain below.
  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_HOLD,
    SRC_EXC,
    SRC_REDIR,
    SRC_RAS
  } src_e;

  src_e                            src;
  logic [RAS_DEPTH-1:0][XLEN-1:0]  ras_mem;
  logic [PW-1:0]                   top_ptr;
  logic [CNT_W-1:0]                ras_cnt;
  logic [XLEN-1:0]                 ras_top;
  logic [XLEN-1:0]                 pc_nxt;
  logic                            ras_push;
  logic                            ras_pop;
  logic                            ras_ovw;
  logic                            take_epc;
  logic                            mis_nxt;
  logic                            und_nxt;
  logic                            ras_we;
  logic [PW-1:0]                   ras_widx;

  assign pc_plus4  = pc + XLEN'(4);
  assign ras_empty = (ras_cnt == '0);
  assign ras_full  = (ras_cnt == CNT_MAX);
  assign ras_top   = ras_mem[top_ptr];

  // Priority decode of the next-PC source and the RAS / pulse side effects.
  always_comb begin
    src      = SRC_SEQ;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    ras_ovw  = 1'b0;
    take_epc = 1'b0;
    mis_nxt  = 1'b0;
    und_nxt  = 1'b0;
    if (exc_req) begin
      // Exceptions beat stall; call/ret are dropped.
      src      = SRC_EXC;
      take_epc = 1'b1;
    end else if (stall) begin
      src = SRC_HOLD;
    end else if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
      src      = SRC_EXC;
      take_epc = 1'b1;
      mis_nxt  = 1'b1;
    end else if (redirect_valid) begin
      // Linked jump: push the return address, any ret is ignored.
      src      = SRC_REDIR;
      ras_push = call;
    end else if (ret && !ras_empty) begin
      src = SRC_RAS;
      // ret+call swaps the top in place instead of pop-then-push.
      if (call) ras_ovw = 1'b1;
      else      ras_pop = 1'b1;
    end else if (ret) begin
      und_nxt  = 1'b1;
      ras_push = call;
    end else begin
      ras_push = call;
    end
  end

  // Next-PC mux.
  always_comb begin
    pc_nxt = pc_plus4;
    case (src)
      SRC_HOLD:  pc_nxt = pc;
      SRC_EXC:   pc_nxt = EXC_VECTOR;
      SRC_REDIR: pc_nxt = redirect_target;
      SRC_RAS:   pc_nxt = ras_top;
      default:   pc_nxt = pc_plus4;
    endcase
  end

  // RAS write port: a push lands one slot above the top (the oldest slot
  // when full), an in-place swap rewrites the current top.
  always_comb begin
    ras_we   = rst && (ras_push || ras_ovw);
    ras_widx = ras_ovw ? top_ptr : top_ptr + PW'(1);
  end

  // RAS storage; contents are don't-care until counted valid, so no reset.
  always_ff @(posedge clk) begin
    if (ras_we) ras_mem[ras_widx] <= pc_plus4;
  end

  // PC, EPC, RAS pointer/count and the one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc            <= RESET_VECTOR;
      epc           <= '0;
      top_ptr       <= '0;
      ras_cnt       <= '0;
      misalign_err  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      pc            <= pc_nxt;
      misalign_err  <= mis_nxt;
      ras_underflow <= und_nxt;
      if (take_epc) epc <= pc;
      if (ras_push) begin
        top_ptr <= top_ptr + PW'(1);
        if (!ras_full) ras_cnt <= ras_cnt + CNT_W'(1);
      end else if (ras_pop) begin
        top_ptr <= top_ptr - PW'(1);
        ras_cnt <= ras_cnt - CNT_W'(1);
      end
    end
  end

endmodule
